axi_timer: RTL
==============

AXI_TIMER -- requirements
Module: axi_timer

Interface
REQ-001 clk_i  input  1  single clock; all logic on rising edge.
REQ-002 rst_i  input  1  reset, synchronous, active-high.
REQ-003 s_arvalid_i  input  1 / s_aready_o  output  1 / s_araddr_i  input  32  read address channel.
REQ-004 s_rvalid_o  output  1 / s_rready_i  input  1 / s_rdata_o  output  32 / s_rresp_o  output  2  read data channel.
REQ-005 s_awvalid_i  input  1 / s_awready_o  output  1 / s_awaddr_i  input  32  write address channel.
REQ-006 s_wvalid_i  input  1 / s_wready_o  output  1 / s_wdata_i  input  32  write data channel (full-word writes only, no strobes).
REQ-007 s_bvalid_o  output  1 / s_bready_i  input  1 / s_bresp_o  output  2  write response channel.
REQ-008 irq_o  output  1  level interrupt = STATUS.match AND CTRL.irq_en.

Function
REQ-009 Decode on addr[4:2] only; other address bits ignored.
REQ-010 Register map: 0x00 CTRL (bit0 en, bit1 irq_en, bit2 auto_reload, others read 0), 0x04 COUNT RW, 0x08 COMPARE RW, 0x0C STATUS (bit0 match, write-1-to-clear), 0x10 PRESCALE RW 32 bit; 0x14-0x1C unmapped.
REQ-011 Response codes: OKAY 2'b00 for mapped offsets; SLVERR 2'b10 for unmapped; unmapped reads return 0, unmapped writes change nothing.
REQ-012 Read FSM states R_IDLE, R_RESP: s_aready_o=1 only in R_IDLE; AR handshake captures rdata/rresp and moves to R_RESP.
REQ-013 In R_RESP s_rvalid_o=1, rdata/rresp held stable until s_rready_i=1, then return to R_IDLE; next AR accepted no earlier than following cycle.
REQ-014 Read latency: s_rvalid_o high the cycle after AR handshake; rdata reflects register values at the handshake edge.
REQ-015 Write path: AW and W accepted independently in any order or same cycle; s_awready_o=1 while no address held and no response pending; s_wready_o=1 while no data held and no response pending.
REQ-016 When address and data both held, register update occurs on next edge and s_bvalid_o rises on that same edge; both holding flags clear.
REQ-017 s_bvalid_o and s_bresp_o held until s_bready_i=1; no new AW/W accepted while s_bvalid_o=1.
REQ-018 Reads and writes proceed concurrently; independent FSMs.
REQ-019 Prescaler counter pcnt: when en=1, pcnt increments each cycle; when pcnt==PRESCALE, pcnt<=0 and one tick generated; en=0 freezes pcnt and COUNT.
REQ-020 On tick: if COUNT==COMPARE then match<=1 and COUNT<=(auto_reload ? 0 : COUNT+1); else COUNT<=COUNT+1, wrapping 0xFFFFFFFF->0.
REQ-021 Software write to COUNT overrides tick update same cycle; write to PRESCALE also clears pcnt.
REQ-022 Hardware set of match wins over simultaneous W1C clear.

Reset
REQ-023 rst_i=1 at an edge: all registers, pcnt, holding flags cleared to 0; FSMs to idle; outputs s_rvalid_o, s_bvalid_o, s_rdata_o, s_rresp_o, s_bresp_o, irq_o = 0; s_aready_o, s_awready_o, s_wready_o = 1 from first cycle after reset.
REQ-024 Reset mid-transaction aborts it; pending response discarded, no register write performed.

Verification
REQ-025 Write 0x08<-5, 0x10<-0, 0x00<-0x7 -> bresp 00; match=1 and irq_o=1 six cycles after en write completes; COUNT reloads to 0.
REQ-026 W presented 3 cycles before AW, s_bready_i held low 4 cycles -> s_bvalid_o stays high, s_awready_o/s_wready_o low until B handshake.
REQ-027 Read 0x14 -> rresp 2'b10, rdata 0; write 0x1C -> bresp 2'b10, no register changed.
REQ-028 COUNT=0xFFFFFFFF, COMPARE=0, en=1, auto_reload=0, PRESCALE=0 -> COUNT wraps to 0 next tick, then match set on following tick.
REQ-029 W1C to STATUS on same cycle as match tick -> match remains 1; irq_en=0 -> irq_o=0 despite match=1.
REQ-030 rst_i asserted while s_rvalid_o=1 and s_rready_i=0 -> next cycle s_rvalid_o=0, s_aready_o=1, all registers read 0.

Source files
------------

// File: rtl/axi_timer_if.sv
// AXI4-Lite style register bus used by axi_timer.
// Signal names keep the slave-side direction suffixes of the timer's port list.
interface axi_timer_if;
  logic        s_arvalid_i;
  logic        s_aready_o;
  logic [31:0] s_araddr_i;
  logic        s_rvalid_o;
  logic        s_rready_i;
  logic [31:0] s_rdata_o;
  logic [1:0]  s_rresp_o;
  logic        s_awvalid_i;
  logic        s_awready_o;
  logic [31:0] s_awaddr_i;
  logic        s_wvalid_i;
  logic        s_wready_o;
  logic [31:0] s_wdata_i;
  logic        s_bvalid_o;
  logic        s_bready_i;
  logic [1:0]  s_bresp_o;

  modport slave (
    input  s_arvalid_i, s_araddr_i, s_rready_i,
    input  s_awvalid_i, s_awaddr_i, s_wvalid_i, s_wdata_i, s_bready_i,
    output s_aready_o, s_rvalid_o, s_rdata_o, s_rresp_o,
    output s_awready_o, s_wready_o, s_bvalid_o, s_bresp_o
  );

  modport master (
    output s_arvalid_i, s_araddr_i, s_rready_i,
    output s_awvalid_i, s_awaddr_i, s_wvalid_i, s_wdata_i, s_bready_i,
    input  s_aready_o, s_rvalid_o, s_rdata_o, s_rresp_o,
    input  s_awready_o, s_wready_o, s_bvalid_o, s_bresp_o
  );
endinterface

// File: rtl/axi_timer.sv
// Prescaled 32-bit up-counter with compare match, sticky status and level IRQ,
// programmed through an AXI-Lite slave with independent read and write paths.
module axi_timer (
  input  logic        clk_i,
  input  logic        rst_i,
  axi_timer_if.slave  bus,
  output logic        irq_o
);

  typedef enum logic {R_IDLE, R_RESP} rd_state_t;

  localparam logic [2:0] ADDR_CTRL     = 3'd0;
  localparam logic [2:0] ADDR_COUNT    = 3'd1;
  localparam logic [2:0] ADDR_COMPARE  = 3'd2;
  localparam logic [2:0] ADDR_STATUS   = 3'd3;
  localparam logic [2:0] ADDR_PRESCALE = 3'd4;
  localparam logic [1:0] RESP_OKAY     = 2'b00;
  localparam logic [1:0] RESP_SLVERR   = 2'b10;

  logic        ctrl_en, ctrl_irq_en, ctrl_auto_reload, status_match;
  logic [31:0] count_q, compare_q, prescale_q, pcnt_q;

  rd_state_t   rd_state;
  logic        aready_q, rvalid_q;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;

  logic        aw_held, w_held, bvalid_q;
  logic [2:0]  awaddr_q;
  logic [31:0] wdata_q;
  logic [1:0]  bresp_q;

  logic        awready, wready, wr_fire, wr_mapped, tick, match_set;
  logic        rd_mapped;
  logic [31:0] rd_mux;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^{bus.s_araddr_i[31:5], bus.s_araddr_i[1:0],
                              bus.s_awaddr_i[31:5], bus.s_awaddr_i[1:0]};

  assign awready   = !aw_held && !bvalid_q;
  assign wready    = !w_held && !bvalid_q;
  assign wr_fire   = aw_held && w_held;
  assign wr_mapped = (awaddr_q <= ADDR_PRESCALE);
  assign tick      = ctrl_en && (pcnt_q == prescale_q);
  assign match_set = tick && (count_q == compare_q);

  always_comb begin
    rd_mux    = 32'd0;
    rd_mapped = 1'b1;
    case (bus.s_araddr_i[4:2])
      ADDR_CTRL:     rd_mux = {29'd0, ctrl_auto_reload, ctrl_irq_en, ctrl_en};
      ADDR_COUNT:    rd_mux = count_q;
      ADDR_COMPARE:  rd_mux = compare_q;
      ADDR_STATUS:   rd_mux = {31'd0, status_match};
      ADDR_PRESCALE: rd_mux = prescale_q;
      default:       rd_mapped = 1'b0;
    endcase
  end

  // Read side: one outstanding read, data frozen until the R handshake.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_state <= R_IDLE;
      aready_q <= 1'b1;
      rvalid_q <= 1'b0;
      rdata_q  <= 32'd0;
      rresp_q  <= RESP_OKAY;
    end else begin
      case (rd_state)
        R_IDLE: if (bus.s_arvalid_i) begin
          rdata_q  <= rd_mux;
          rresp_q  <= rd_mapped ? RESP_OKAY : RESP_SLVERR;
          rvalid_q <= 1'b1;
          aready_q <= 1'b0;
          rd_state <= R_RESP;
        end
        R_RESP: if (bus.s_rready_i) begin
          rvalid_q <= 1'b0;
          aready_q <= 1'b1;
          rd_state <= R_IDLE;
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      awaddr_q <= 3'd0;
      wdata_q  <= 32'd0;
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
    end else begin
      if (bus.s_awvalid_i && awready) begin
        aw_held  <= 1'b1;
        awaddr_q <= bus.s_awaddr_i[4:2];
      end
      if (bus.s_wvalid_i && wready) begin
        w_held  <= 1'b1;
        wdata_q <= bus.s_wdata_i;
      end
      if (wr_fire) begin
        aw_held  <= 1'b0;
        w_held   <= 1'b0;
        bvalid_q <= 1'b1;
        bresp_q  <= wr_mapped ? RESP_OKAY : RESP_SLVERR;
      end else if (bvalid_q && bus.s_bready_i) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  // Software writes are placed after the tick update so they take priority.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctrl_en          <= 1'b0;
      ctrl_irq_en      <= 1'b0;
      ctrl_auto_reload <= 1'b0;
      status_match     <= 1'b0;
      count_q          <= 32'd0;
      compare_q        <= 32'd0;
      prescale_q       <= 32'd0;
      pcnt_q           <= 32'd0;
    end else begin
      if (tick) begin
        pcnt_q  <= 32'd0;
        count_q <= (match_set && ctrl_auto_reload) ? 32'd0 : count_q + 32'd1;
      end else if (ctrl_en) begin
        pcnt_q <= pcnt_q + 32'd1;
      end
      if (match_set) begin
        status_match <= 1'b1;
      end else if (wr_fire && awaddr_q == ADDR_STATUS && wdata_q[0]) begin
        status_match <= 1'b0;
      end
      if (wr_fire) begin
        case (awaddr_q)
          ADDR_CTRL: begin
            ctrl_en          <= wdata_q[0];
            ctrl_irq_en      <= wdata_q[1];
            ctrl_auto_reload <= wdata_q[2];
          end
          ADDR_COUNT:   count_q   <= wdata_q;
          ADDR_COMPARE: compare_q <= wdata_q;
          ADDR_PRESCALE: begin
            prescale_q <= wdata_q;
            pcnt_q     <= 32'd0;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.s_aready_o  = aready_q;
  assign bus.s_rvalid_o  = rvalid_q;
  assign bus.s_rdata_o   = rdata_q;
  assign bus.s_rresp_o   = rresp_q;
  assign bus.s_awready_o = awready;
  assign bus.s_wready_o  = wready;
  assign bus.s_bvalid_o  = bvalid_q;
  assign bus.s_bresp_o   = bresp_q;
  assign irq_o           = status_match && ctrl_irq_en;

endmodule
